// File: rtl/instr_encoder_pkg.sv
// Shared op codes, RV32 opcode/funct constants and the FIFO entry layout
// used by the encoder and anything that decodes the same op field.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_MUL   = 3'd2,
      OP_DIV   = 3'd3,
      OP_LOAD  = 3'd4,
      OP_STORE = 3'd5,
      OP_ILL6  = 3'd6,
      OP_ILL7  = 3'd7
   } op_e;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } fifo_entry_t;

   function automatic logic is_legal(input op_e op);
      return (op != OP_ILL6) && (op != OP_ILL7);
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO, one-cycle write-to-read latency, sync clear.
// Caller must not push when full; head data reads as zero while empty.
module instr_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_dat,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rd_dat,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level   = wr_q - rd_q;
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign rd_dat  = empty ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clear) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes op/register/imm requests into RV32 words tagged with a running byte
// address; one-cycle latency through a FIFO, in_ready drops when full or clearing.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_op,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   input  logic [11:0]            in_imm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_addr,
   output logic                   err_illegal,
   output logic [7:0]             illegal_cnt,
   output logic [$clog2(DEPTH):0] level
);

   function automatic logic [31:0] encode(input op_e op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
      logic [31:0] w;
      w = '0;
      case (op)
         OP_ADD:   w = {F7_BASE,   rs2, rs1, F3_ADD, rd, OPC_RTYPE};
         OP_SUB:   w = {F7_SUB,    rs2, rs1, F3_ADD, rd, OPC_RTYPE};
         OP_MUL:   w = {F7_MULDIV, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
         OP_DIV:   w = {F7_MULDIV, rs2, rs1, F3_DIV, rd, OPC_RTYPE};
         OP_LOAD:  w = {imm, rs1, F3_WORD, rd, OPC_LOAD};
         OP_STORE: w = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
         default:  w = '0;
      endcase
      return w;
   endfunction

   op_e         op;
   logic        accept, legal, push, pop, full, empty;
   logic [31:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   fifo_entry_t push_entry, head;

   assign op         = op_e'(in_op);
   // Gating with rst_n keeps in_ready low for the whole reset assertion.
   assign in_ready   = rst_n && !full && !clear;
   assign accept     = in_valid && in_ready;
   assign legal      = is_legal(op);
   assign push       = accept && legal;
   assign out_valid  = !empty;
   assign pop        = out_valid && out_ready;
   assign push_entry = '{instr: encode(op, in_rd, in_rs1, in_rs2, in_imm), addr: addr_q};

   always_comb begin
      addr_d = addr_q;
      err_d  = err_q;
      cnt_d  = cnt_q;
      if (clear) begin
         addr_d = BASE_ADDR;
         err_d  = 1'b0;
         cnt_d  = '0;
      end else if (accept) begin
         if (legal) begin
            addr_d = addr_q + 32'd4;
         end else begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= BASE_ADDR;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .rd_dat   (head),
      .full     (full),
      .empty    (empty),
      .level    (level)
   );

   assign out_instr   = head.instr;
   assign out_addr    = head.addr;
   assign err_illegal = err_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors with hand-computed words,
// plus a second instance built with BASE_ADDR=32'h100 for the clear/base check.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, out_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [11:0] in_imm;

   logic        in_ready, out_valid, err_illegal;
   logic [31:0] out_instr, out_addr;
   logic [7:0]  illegal_cnt;
   logic [2:0]  level;

   logic        b_in_ready, b_out_valid, b_err_illegal;
   logic [31:0] b_out_instr, b_out_addr;
   logic [7:0]  b_illegal_cnt;
   logic [2:0]  b_level;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err_illegal(err_illegal), .illegal_cnt(illegal_cnt), .level(level)
   );

   instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0100)) u_dut_base (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_instr(b_out_instr), .out_addr(b_out_addr),
      .err_illegal(b_err_illegal), .illegal_cnt(b_illegal_cnt), .level(b_level)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      logic [31:0] word;
   } vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   vec_t        vt[6];
   logic [31:0] exp_addr;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && !clear && out_valid && out_ready) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got instr %h addr %h, expected no output",
                     out_instr, out_addr);
         end else begin
            mon_e = sb_q.pop_front();
            if (out_instr !== mon_e.instr || out_addr !== mon_e.addr) begin
               n_bad++;
               $display("FAIL pop_data: got instr %h addr %h, expected instr %h addr %h",
                        out_instr, out_addr, mon_e.instr, mon_e.addr);
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm,
                       input bit legal, input logic [31:0] word);
      bit got;
      int n;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
      in_valid = 1'b1;
      got      = 1'b0;
      n        = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         got = in_ready;
         n++;
      end
      if (!got) begin
         check("send_timeout_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      if (legal) begin
         sb_q.push_back('{instr: word, addr: exp_addr});
         exp_addr = exp_addr + 32'd4;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input int i);
      send(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b1, vt[i].word);
   endtask

   task automatic pulse_clear();
      in_valid = 1'b0;
      clear    = 1'b1;
      #1;
      check("clear_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      sb_q.delete();
      exp_addr = 32'h0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check("drain_left", 32'(sb_q.size()), 32'd0);
      check("drain_level", 32'(level), 32'd0);
   endtask

   initial begin
      // ADD x3,x1,x2 with junk imm; LOAD/STORE carry junk in the ignored field.
      vt[0] = '{op: 3'd0, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  imm: 12'hFFF, word: 32'h002081B3};
      vt[1] = '{op: 3'd1, rd: 5'd5,  rs1: 5'd6,  rs2: 5'd7,  imm: 12'h000, word: 32'h407302B3};
      vt[2] = '{op: 3'd3, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  imm: 12'h000, word: 32'h023140B3};
      vt[3] = '{op: 3'd4, rd: 5'd4,  rs1: 5'd2,  rs2: 5'd31, imm: 12'd8,   word: 32'h00812203};
      vt[4] = '{op: 3'd5, rd: 5'd31, rs1: 5'd10, rs2: 5'd9,  imm: 12'd12,  word: 32'h00952623};
      vt[5] = '{op: 3'd2, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  imm: 12'h000, word: 32'h023100B3};

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      exp_addr = 32'h0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr",  out_addr, 32'd0);
      check("rst_level",     32'(level), 32'd0);
      check("rst_err",       32'(err_illegal), 32'd0);
      check("rst_cnt",       32'(illegal_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      out_ready = 1'b1;
      send_vec(0);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      drain();

      pulse_clear();
      for (int i = 1; i < 6; i++) send_vec(i);
      drain();

      pulse_clear();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_vec(i);
      check("full_level",    32'(level), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      send_vec(4);
      check("pushpop_level", 32'(level), 32'd3);
      drain();

      pulse_clear();
      send_vec(0);
      send(3'd6, 5'd1, 5'd1, 5'd1, 12'h0, 1'b0, 32'h0);
      send_vec(0);
      check("ill_err", 32'(err_illegal), 32'd1);
      check("ill_cnt", 32'(illegal_cnt), 32'd1);
      drain();
      for (int i = 0; i < 300; i++) send(3'd7, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0, 32'h0);
      check("ill_cnt_sat", 32'(illegal_cnt), 32'd255);
      check("ill_level",   32'(level), 32'd0);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_vec(i);
      check("pre_rst_level", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_instr", out_instr, 32'd0);
      check("arst_level",     32'(level), 32'd0);
      check("arst_in_ready",  32'(in_ready), 32'd0);
      check("arst_cnt",       32'(illegal_cnt), 32'd0);
      sb_q.delete();
      exp_addr = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready",  32'(in_ready), 32'd1);
      check("rel_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      send_vec(0);
      send(3'd6, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0, 32'h0);
      send_vec(1);
      check("pre_clr_err", 32'(err_illegal), 32'd1);
      pulse_clear();
      check("clr_level", 32'(level), 32'd0);
      check("clr_err",   32'(err_illegal), 32'd0);
      check("clr_cnt",   32'(illegal_cnt), 32'd0);
      send_vec(3);
      check("clr_addr_base0",   out_addr, 32'h0000_0000);
      check("clr_addr_base100", b_out_addr, 32'h0000_0100);
      check("clr_instr_base100", b_out_instr, 32'h00812203);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address assigned to the first legal instruction after reset or clear.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush: empty FIFO, reload address counter, clear error state.
REQ-006 in_valid  input  1  request carries a field set to encode.
REQ-007 in_ready  output  1  encoder accepts request this cycle.
REQ-008 in_op  input  3  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD (LW), 5 STORE (SW), 6-7 illegal.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-010 in_imm  input  12  offset for LOAD/STORE; ignored for R-type.
REQ-011 out_valid  output  1  FIFO head holds an encoded instruction.
REQ-012 out_ready  input  1  consumer (e.g. instruction memory writer) takes head.
REQ-013 out_instr  output  32  encoded RV32 instruction word at head.
REQ-014 out_addr  output  32  byte address bound to out_instr.
REQ-015 err_illegal  output  1  sticky: an illegal op was accepted.
REQ-016 illegal_cnt  output  8  count of illegal ops accepted, saturating at 255.
REQ-017 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 R-type (op 0-3): opcode 7'b0110011, [11:7]=rd, [19:15]=rs1, [24:20]=rs2; {funct7,funct3} = ADD 0000000_000, SUB 0100000_000, MUL 0000001_000, DIV 0000001_100.
REQ-019 LOAD: opcode 7'b0000011, funct3 3'b010, [31:20]=imm, [19:15]=rs1, [11:7]=rd; rs2 ignored.
REQ-020 STORE: opcode 7'b0100011, funct3 3'b010, [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [11:7]=imm[4:0]; rd ignored.
REQ-021 in_ready = !full && !clear; handshake completes when in_valid && in_ready.
REQ-022 Legal accepted op: encoded word and current address counter pushed into FIFO; counter += 4, wrapping mod 2^32.
REQ-023 Illegal accepted op: nothing pushed, counter unchanged, err_illegal <= 1, illegal_cnt increments unless 255.
REQ-024 Latency: push at edge N makes out_valid=1 after edge N when FIFO was empty; no combinational path in->out.
REQ-025 out_valid = !empty; pop when out_valid && out_ready; out_instr/out_addr stable while out_valid && !out_ready.
REQ-026 Simultaneous push and pop: both occur, level unchanged; permitted at any non-full level; when full, no push (in_ready=0) even if pop occurs that cycle.
REQ-027 Pointers wrap modulo DEPTH; full/empty distinguished by extra pointer bit.
REQ-028 clear has priority over push/pop that cycle: level=0, counter=BASE_ADDR, err_illegal=0, illegal_cnt=0.

Reset
REQ-029 On rst_n low, asynchronously: FIFO empty, out_valid=0, in_ready=0 while asserted, out_instr=0, out_addr=0, address counter=BASE_ADDR, err_illegal=0, illegal_cnt=0, level=0.
REQ-030 Reset mid-transfer discards all FIFO contents; first cycle after release in_ready=1.

Structure
REQ-031 Shared package holds op codes (OP_ADD..OP_STORE), opcode constants (OPC_RTYPE, OPC_LOAD, OPC_STORE), funct3/funct7 constants, and the same op enum the decoder consumes.
REQ-032 Encoding is a combinational function in the top; storage is sub-module instr_fifo (DEPTH x 64 bits, instr+addr).

Verification
REQ-033 ADD rd=3 rs1=1 rs2=2 after reset -> next cycle out_instr=32'h002081B3, out_addr=0.
REQ-034 SUB 5,6,7 then DIV 1,2,3 -> 32'h407302B3 @0, 32'h023140B3 @4, in order.
REQ-035 LOAD rd=4 rs1=2 imm=8 -> 32'h00812203; STORE rs2=9 rs1=10 imm=12 -> 32'h00952623.
REQ-036 out_ready=0, push 5 ops with DEPTH=4 -> in_ready=0 after 4th, level=4; one pop + pending push same cycle -> level stays 4 only if push precedes full; verify no loss, addresses 0,4,8,12,16.
REQ-037 op=6 accepted between two ADDs -> err_illegal=1, illegal_cnt=1, addresses 0 and 4 (no gap); 300 illegal ops -> illegal_cnt=255.
REQ-038 rst_n low with 3 entries queued -> out_valid=0 immediately; clear with BASE_ADDR=32'h100 -> next out_addr=32'h100.
